// File: rtl/hdmi_timing_ctrl.sv
// Raster timing generator for an HDMI/DVI pixel pipeline: pixel/line counters,
// data-enable, syncs, a one-cycle-early fetch request and frame bookkeeping.
module hdmi_timing_ctrl #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        enable,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_req,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_BEGIN = 11'(H_ACTIVE);
  localparam logic [10:0] H_SY_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_BEGIN = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_FP_BEGIN = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SY_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_BP_BEGIN = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} run_state_e;
  typedef enum logic [1:0] {PH_ACT, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  // Horizontal sub-state for a given column.
  function automatic phase_e h_phase_of(input logic [10:0] h);
    phase_e ph;
    if (h < H_FP_BEGIN) begin
      ph = PH_ACT;
    end else if (h < H_SY_BEGIN) begin
      ph = PH_FRONT;
    end else if (h < H_BP_BEGIN) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BACK;
    end
    return ph;
  endfunction

  // Vertical sub-state for a given line.
  function automatic phase_e v_phase_of(input logic [9:0] v);
    phase_e ph;
    if (v < V_FP_BEGIN) begin
      ph = PH_ACT;
    end else if (v < V_SY_BEGIN) begin
      ph = PH_FRONT;
    end else if (v < V_BP_BEGIN) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BACK;
    end
    return ph;
  endfunction

  run_state_e  state_q, state_d;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        run_d;
  logic        h_end_s, v_end_s, frame_end_s;
  phase_e      h_phase_d, v_phase_d;

  assign h_end_s     = (hcount_q == H_LAST);
  assign v_end_s     = (vcount_q == V_LAST);
  assign frame_end_s = h_end_s && v_end_s;

  // Next run state and counters; a frame only ends early through reset.
  always_comb begin
    state_d       = state_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        hcount_d = 11'd0;
        vcount_d = 10'd0;
        if (enable) begin
          state_d       = ST_RUN;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (frame_end_s && !enable) begin
          state_d  = ST_IDLE;
          hcount_d = 11'd0;
          vcount_d = 10'd0;
        end else begin
          state_d = enable ? ST_RUN : ST_DRAIN;
          if (h_end_s) begin
            hcount_d = 11'd0;
            vcount_d = v_end_s ? 10'd0 : vcount_q + 10'd1;
          end else begin
            hcount_d = hcount_q + 11'd1;
            vcount_d = vcount_q;
          end
          if (frame_end_s) begin
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
          end else begin
            frame_start_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        hcount_d = 11'd0;
        vcount_d = 10'd0;
      end
    endcase
  end

  // Video qualifiers are decoded from the next position so they register alongside it.
  always_comb begin
    run_d     = (state_d != ST_IDLE);
    h_phase_d = h_phase_of(hcount_d);
    v_phase_d = v_phase_of(vcount_d);
    de_d      = run_d && (h_phase_d == PH_ACT) && (v_phase_d == PH_ACT);
    if (run_d && (h_phase_d == PH_SYNC)) begin
      hsync_d = SYNC_POL;
    end else begin
      hsync_d = !SYNC_POL;
    end
    if (run_d && (v_phase_d == PH_SYNC)) begin
      vsync_d = SYNC_POL;
    end else begin
      vsync_d = !SYNC_POL;
    end
  end

  // Fetch request is the next-cycle data-enable, held low while in reset.
  assign pix_req = de_d && reset;

  // Timing state registers.
  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      de_q          <= 1'b0;
      hsync_q       <= !SYNC_POL;
      vsync_q       <= !SYNC_POL;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
